// File: rtl/ntt_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// ntt_op_sequencer_pkg : op codes, generator sel encodings and FSM states
// Revision : 1.0
// ============================================================================
package ntt_op_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_NTT  = 2'd0,
      OP_INTT = 2'd1,
      OP_PWM  = 2'd2,
      OP_PWA  = 2'd3
   } op_t;

   // Must match the address generator's decode of sel.
   localparam logic [2:0] SEL_IDLE = 3'b000;
   localparam logic [2:0] SEL_NTT  = 3'b001;
   localparam logic [2:0] SEL_INTT = 3'b100;
   localparam logic [2:0] SEL_PWM  = 3'b010;
   localparam logic [2:0] SEL_PWA  = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   localparam int CMD_W = 6;

   function automatic logic [2:0] op_to_sel(input op_t op);
      case (op)
         OP_NTT:  op_to_sel = SEL_NTT;
         OP_INTT: op_to_sel = SEL_INTT;
         OP_PWM:  op_to_sel = SEL_PWM;
         default: op_to_sel = SEL_PWA;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_op_sequencer_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock command FIFO with fall-through head read
// Revision : 1.0
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ntt_op_sequencer.sv
`default_nettype none
// ============================================================================
// ntt_op_sequencer : queues NTT/INTT/PWM/PWA commands and sequences them onto
//                    the address generator sel bus with timeout and halt
// Revision : 1.0
// ============================================================================
module ntt_op_sequencer
   import ntt_op_sequencer_pkg::*;
#(
   parameter int TIMEOUT    = 1023,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_tag,
   output logic [2:0] sel,
   input  logic       done_flag,
   output logic       rsp_valid,
   output logic [3:0] rsp_tag,
   output logic       rsp_err,
   input  logic       err_clear,
   output logic       busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       tag_q;
   logic [CMD_W-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;

   assign cmd_ready = !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
   assign busy      = (state != ST_IDLE) || !fifo_empty;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({cmd_op, cmd_tag}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         sel       <= SEL_IDLE;
         cnt       <= '0;
         tag_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_tag   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  tag_q <= fifo_dout[3:0];
                  sel   <= op_to_sel(op_t'(fifo_dout[5:4]));
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Completion takes priority over a coincident timeout.
               if (done_flag) begin
                  rsp_valid <= 1'b1;
                  rsp_tag   <= tag_q;
                  sel       <= SEL_IDLE;
                  state     <= ST_GAP;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_tag   <= tag_q;
                  sel       <= SEL_IDLE;
                  state     <= ST_HALT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_GAP: state <= ST_IDLE;
            ST_HALT: begin
               if (err_clear) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ntt_op_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ntt_op_sequencer : directed vectors for the NTT op sequencer
// Revision : 1.0
// ============================================================================
module tb_ntt_op_sequencer;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_tag;
   logic [2:0] sel;
   logic       done_flag;
   logic       rsp_valid;
   logic [3:0] rsp_tag;
   logic       rsp_err;
   logic       err_clear;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ntt_op_sequencer #(
      .TIMEOUT    (1023),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_tag   (cmd_tag),
      .sel       (sel),
      .done_flag (done_flag),
      .rsp_valid (rsp_valid),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err),
      .err_clear (err_clear),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sel(input logic [2:0] exp, input string name);
      int t = 0;
      while (sel !== exp && t < 64) begin
         t++;
         tick();
      end
      chk(name, 32'(sel), 32'(exp));
   endtask

   task automatic push(input logic [1:0] op, input logic [3:0] tag);
      int t = 0;
      cmd_op    = op;
      cmd_tag   = tag;
      cmd_valid = 1'b1;
      while (!cmd_ready && t < 64) begin
         t++;
         tick();
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   logic [2:0] exp_sel [5] = '{3'b001, 3'b100, 3'b010, 3'b110, 3'b100};
   logic [1:0] ops5    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};

   initial begin
      int n;
      int z;
      logic bad;
      rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_tag = '0;
      done_flag = 1'b0; err_clear = 1'b0;
      #1;
      chk("rst_sel", 32'(sel), 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_rsp_tag", 32'(rsp_tag), 0);
      chk("rst_busy", 32'(busy), 0);
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      // Spurious done while idle
      done_flag = 1'b1; tick(); done_flag = 1'b0;
      chk("idle_spur_rsp", 32'(rsp_valid), 0);
      chk("idle_spur_sel", 32'(sel), 0);
      chk("idle_spur_busy", 32'(busy), 0);

      // Single NTT, done on the 234th RUN cycle
      push(2'd0, 4'd5);
      chk("q_busy", 32'(busy), 1);
      wait_sel(3'b001, "ntt_issue");
      n = 1;
      repeat (233) begin
         tick();
         if (sel == 3'b001) n++;
      end
      done_flag = 1'b1; tick(); done_flag = 1'b0;
      chk("ntt_run_cycles", 32'(n), 234);
      chk("ntt_rsp_valid", 32'(rsp_valid), 1);
      chk("ntt_rsp_tag", 32'(rsp_tag), 5);
      chk("ntt_rsp_err", 32'(rsp_err), 0);
      chk("ntt_gap_sel", 32'(sel), 0);
      tick();
      chk("ntt_rsp_pulse", 32'(rsp_valid), 0);
      chk("ntt_idle_sel", 32'(sel), 0);
      chk("ntt_idle_busy", 32'(busy), 0);

      // Five back-to-back commands
      for (int i = 0; i < 5; i++) begin
         cmd_op = ops5[i]; cmd_tag = 4'(i + 1); cmd_valid = 1'b1;
         chk($sformatf("b2b_ready%0d", i), 32'(cmd_ready), 1);
         tick();
      end
      cmd_valid = 1'b0;
      chk("b2b_full", 32'(cmd_ready), 0);
      for (int k = 0; k < 5; k++) begin
         if (k == 0) wait_sel(exp_sel[0], "b2b_sel0");
         else        chk($sformatf("b2b_sel%0d", k), 32'(sel), 32'(exp_sel[k]));
         repeat (2) tick();
         done_flag = 1'b1; tick(); done_flag = 1'b0;
         chk($sformatf("b2b_rsp%0d", k), 32'(rsp_valid), 1);
         chk($sformatf("b2b_tag%0d", k), 32'(rsp_tag), 32'(k + 1));
         chk($sformatf("b2b_err%0d", k), 32'(rsp_err), 0);
         if (k == 0) begin
            done_flag = 1'b1; tick(); done_flag = 1'b0;
            chk("gap_spur_rsp", 32'(rsp_valid), 0);
            chk("gap_spur_sel", 32'(sel), 0);
            tick();
         end else if (k < 4) begin
            z = 0;
            while (sel == 3'b000 && z < 20) begin
               z++;
               tick();
            end
            chk($sformatf("b2b_spacing%0d", k), 32'(z), 2);
         end
      end
      tick();
      chk("b2b_done_busy", 32'(busy), 0);

      // Timeout on PWA, HALT, then err_clear releases queued NTT
      push(2'd3, 4'd9);
      push(2'd0, 4'd3);
      wait_sel(3'b110, "pwa_issue");
      n = 0;
      while (sel == 3'b110 && n < 1100) begin
         n++;
         tick();
      end
      chk("to_run_cycles", 32'(n), 1024);
      chk("to_rsp_valid", 32'(rsp_valid), 1);
      chk("to_rsp_err", 32'(rsp_err), 1);
      chk("to_rsp_tag", 32'(rsp_tag), 9);
      chk("to_sel", 32'(sel), 0);
      tick();
      chk("halt_rsp_pulse", 32'(rsp_valid), 0);
      chk("halt_busy", 32'(busy), 1);
      chk("halt_ready", 32'(cmd_ready), 1);
      repeat (5) tick();
      chk("halt_no_pop", 32'(sel), 0);
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      chk("clr_idle_sel", 32'(sel), 0);
      tick();
      chk("clr_issue", 32'(sel), 32'(3'b001));
      tick();
      done_flag = 1'b1; tick(); done_flag = 1'b0;
      chk("clr_rsp_tag", 32'(rsp_tag), 3);
      chk("clr_rsp_err", 32'(rsp_err), 0);
      repeat (2) tick();

      // done coincident with counter == TIMEOUT
      push(2'd2, 4'd7);
      wait_sel(3'b010, "pwm_issue");
      repeat (1023) tick();
      done_flag = 1'b1; tick(); done_flag = 1'b0;
      chk("edge_rsp_valid", 32'(rsp_valid), 1);
      chk("edge_rsp_err", 32'(rsp_err), 0);
      chk("edge_rsp_tag", 32'(rsp_tag), 7);
      tick();
      chk("edge_not_halt", 32'(busy), 0);

      // Reset mid-INTT with two queued
      push(2'd1, 4'd10);
      push(2'd2, 4'd11);
      push(2'd0, 4'd12);
      wait_sel(3'b100, "intt_issue");
      repeat (3) tick();
      #2 rstn = 1'b0;
      #1;
      chk("arst_sel", 32'(sel), 0);
      chk("arst_ready", 32'(cmd_ready), 1);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_rsp", 32'(rsp_valid), 0);
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (rsp_valid || sel != 3'b000 || busy) bad = 1'b1;
      end
      chk("post_rst_quiet", 32'(bad), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
